// File: rtl/memShare_config_pkg.sv
// Shared-memory configuration constants and types for SCU.memShare().
// Holds the column-address width and the skid FSM state encoding.
package memShare_config_pkg;

    localparam int COL_ADDR_W = 8;

    typedef enum logic {
        SKID_PASS,
        SKID_HOLD
    } skid_state_e;

endpackage

// File: rtl/memshare_coladdr_skid.sv
// One-entry column-address skid buffer feeding the shared-memory column port.
// A skidded address and everything behind it is delayed one cycle until a gap.
module memshare_coladdr_skid #(
    parameter int COL_ADDR_W = memShare_config_pkg::COL_ADDR_W,
    parameter int SKID_CNT_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  scu_memShare_busy_i,
    input  logic                  isColAddr_skid_i,
    input  logic [COL_ADDR_W-1:0] colAddr_i,
    input  logic                  colAddr_vld_i,
    output logic [COL_ADDR_W-1:0] colAddr_o,
    output logic                  colAddr_vld_o,
    output logic                  skid_active_o,
    output logic                  skid_err_o,
    output logic [SKID_CNT_W-1:0] skid_cnt_o
);

    import memShare_config_pkg::*;

    skid_state_e           state_q, state_d;
    logic [COL_ADDR_W-1:0] skid_q, skid_d;
    logic [COL_ADDR_W-1:0] addr_q, addr_d;
    logic                  vld_q, vld_d;
    logic                  err_q, err_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  skid_req;

    assign skid_req = isColAddr_skid_i & colAddr_vld_i & scu_memShare_busy_i;

    always_comb begin
        state_d = state_q;
        skid_d  = skid_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SKID_PASS: begin
                if (skid_req) begin
                    skid_d  = colAddr_i;
                    vld_d   = 1'b0;
                    state_d = SKID_HOLD;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else begin
                    addr_d = colAddr_i;
                    vld_d  = colAddr_vld_i;
                end
            end
            SKID_HOLD: begin
                addr_d = skid_q;
                vld_d  = 1'b1;
                // A second skid here is a rule violation but is treated as plain data
                if (skid_req) err_d = 1'b1;
                if (colAddr_vld_i) skid_d = colAddr_i;
                else state_d = SKID_PASS;
            end
            default: state_d = SKID_PASS;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= SKID_PASS;
            skid_q  <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign colAddr_o     = addr_q;
    assign colAddr_vld_o = vld_q;
    assign skid_active_o = (state_q == SKID_HOLD);
    assign skid_err_o    = err_q;
    assign skid_cnt_o    = cnt_q;

endmodule
